usb_tx_encoder: RTL and testbench
=================================

# usb_tx_encoder

- Upstream neighbour of the USB transceiver selector; drives its `d_plus_out`, `d_minus_out` and `transmitting` inputs.
- Takes a byte stream from the packet layer over a valid/ready handshake and emits one full-speed USB packet on the line: SYNC, then LSB-first data with bit stuffing, NRZI encoding, then EOP.
- Holds the line in idle J while not transmitting, so the selector always sees a defined line state.

## Interface
- `CLKS_PER_BIT`, default 8: clock cycles per USB bit time; must be ≥ 2.
- `clk`  in  1  system clock.
- `n_rst`  in  1  reset, asynchronous, active-low.
- `tx_valid`  in  1  upstream has a byte on `tx_data`.
- `tx_data`  in  8  byte to send, LSB first.
- `tx_last`  in  1  qualifies `tx_data` as the final byte of the packet.
- `tx_ready`  out  1  encoder accepts `tx_data` this cycle if `tx_valid` is high.
- `d_plus_out`  out  1  D+ drive value to the transceiver selector.
- `d_minus_out`  out  1  D− drive value to the transceiver selector.
- `transmitting`  out  1  high while the packet is driven, including EOP.
- `tx_done`  out  1  one-cycle pulse when the packet ends normally.
- `tx_underrun`  out  1  one-cycle pulse when the packet ends because no byte arrived in time.

## Operation
- **States:** IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J.
- **Counters:**
  - divider counts 0..CLKS_PER_BIT-1; a bit ends when divider = CLKS_PER_BIT-1.
  - 3-bit bit index.
  - 3-bit ones counter.
- **Line encoding:** J = (D+ 1, D− 0); K = (0, 1); SE0 = (0, 0).
- **NRZI:** a 0 bit toggles J↔K; a 1 bit holds the current state. The line state before SYNC is J.
- **IDLE:**
  - `tx_ready`=1.
  - On `tx_valid`: latch `tx_data` and `tx_last`, clear the ones counter, go to SYNC.
- **SYNC:** send 0x80 LSB first (seven 0s, then one 1). SYNC bits count toward stuffing, so the ones counter ends at 1. Then go to DATA.
- **DATA:**
  - Each 1 bit increments the ones counter; each 0 bit clears it.
  - When the counter reaches 6 after a bit, go to STUFF before the next bit.
- **STUFF:** one bit time of 0 (line toggles), clear the ones counter, resume DATA or go to the byte boundary.
- **Byte boundary:** after bit 7 and any pending stuff bit.
  - Latched `tx_last` set: go to EOP_SE0 and raise `tx_done` at the end of the packet.
  - Otherwise `tx_ready`=1 on that final cycle.
    - If `tx_valid`: load the next byte, continue DATA with no gap.
    - If `tx_valid` is low: go to EOP_SE0 and pulse `tx_underrun` at the end of the packet (not `tx_done`).
- **EOP_SE0:** two bit times of SE0.
- **EOP_J:** one bit time of J. On its last cycle, go to IDLE and pulse `tx_done` or `tx_underrun`.
- `tx_ready`=0 in all other states and cycles.
- **Reset (async, any time, including mid-packet):**
  - state IDLE; line J (`d_plus_out`=1, `d_minus_out`=0); `transmitting`=0.
  - `tx_done`=0, `tx_underrun`=0, all counters 0.
  - `tx_ready`=1 (IDLE).
  - No EOP is emitted for an aborted packet.

## Timing
- `tx_ready` is combinational from state and counters. A transfer happens on the rising edge where `tx_valid` and `tx_ready` are both high.
- `d_plus_out`, `d_minus_out` and `transmitting` are registered.
  - `transmitting` rises, and the first SYNC bit appears, one cycle after the accepting edge.
  - `transmitting` falls on the cycle after the last EOP_J cycle, together with the `tx_done`/`tx_underrun` pulse.
- Each bit, including stuff and EOP bits, is held exactly CLKS_PER_BIT cycles.
- Packet duration in cycles = CLKS_PER_BIT × (8 + 8·N + stuffed bits + 3).
- Back-to-back packets: a new `tx_valid` is accepted in the first IDLE cycle, which gives at least one idle J cycle between packets.

## Configuration
- **`USB_TX_BITSTUFF_EN` defined:** bit stuffing as described above; STUFF state present.
- **`USB_TX_BITSTUFF_EN` undefined:**
  - STUFF state and ones counter removed; no stuff bits ever inserted.
  - Packet duration is CLKS_PER_BIT × (11 + 8·N).
  - Intended only for raw NRZI bring-up.

## Test plan
- **Reset:** assert `n_rst` low → `d_plus_out`=1, `d_minus_out`=0, `transmitting`=0, `tx_ready`=1, no pulses.
- **Single byte, no stuffing:** 0x00 with `tx_last`, CLKS_PER_BIT=8 → bit sequence K J K J K J K K, J K J K J K J K, SE0 SE0 J. `transmitting` high for 152 cycles, then `tx_done` pulse.
- **Single byte, stuffing:** 0xFF with `tx_last` and `USB_TX_BITSTUFF_EN` → K held for SYNC bit 8 plus data bits 1–5, stuff toggles to J, J held for 3 bits, then EOP. 160 cycles total. Without the macro: 152 cycles and no toggle.
- **Two bytes back-to-back:** 0xA5, then 0x3C with `tx_last` → `tx_ready` high exactly one cycle at the end of data bit 7 of the first byte. No gap between bytes; 216 cycles.
- **Underrun:** 0x01 without `tx_last`, then `tx_valid` low → EOP follows byte 1 directly, `tx_underrun` pulses once, `tx_done` stays 0.
- **Mid-packet reset:** drop `n_rst` during DATA → line returns to J and `transmitting`=0 asynchronously. After release, the next packet starts with a clean SYNC.

Source files
------------

// File: rtl/usb_tx_encoder.sv
// Full-speed USB packet transmitter: SYNC, LSB-first NRZI data, EOP, idle J.
// Bit stuffing is present only when USB_TX_BITSTUFF_EN is defined.
module usb_tx_encoder #(
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       d_plus_out,
  output logic       d_minus_out,
  output logic       transmitting,
  output logic       tx_done,
  output logic       tx_underrun
);

  localparam int unsigned DIV_W = $clog2(CLKS_PER_BIT);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLKS_PER_BIT - 1);

`ifdef USB_TX_BITSTUFF_EN
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SYNC    = 3'd1,
    S_DATA    = 3'd2,
    S_STUFF   = 3'd3,
    S_EOP_SE0 = 3'd4,
    S_EOP_J   = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SYNC    = 3'd1,
    S_DATA    = 3'd2,
    S_EOP_SE0 = 3'd4,
    S_EOP_J   = 3'd5
  } state_t;
`endif

  state_t           r_state, w_state_nxt;
  logic [DIV_W-1:0] r_div, w_div_nxt;
  logic [2:0]       r_bit, w_bit_nxt;
  logic [7:0]       r_byte, w_byte_nxt;
  logic             r_last, w_last_nxt;
  logic             r_nrzi, w_nrzi_nxt;   // 1 = J, 0 = K
  logic             r_dp, r_dm, r_tx, r_done, r_underrun;
  logic             w_tx_nxt, w_done_nxt, w_underrun_nxt;
  logic             w_bit_end, w_boundary, w_ready, w_emit, w_emit_val;
`ifdef USB_TX_BITSTUFF_EN
  logic [2:0]       r_ones, w_ones_nxt;
`endif

  assign w_bit_end = (r_div == DIV_MAX);

  always_comb begin
    w_state_nxt    = r_state;
    w_div_nxt      = (r_state == S_IDLE || w_bit_end) ? '0 : r_div + DIV_W'(1);
    w_bit_nxt      = r_bit;
    w_byte_nxt     = r_byte;
    w_last_nxt     = r_last;
    w_nrzi_nxt     = r_nrzi;
    w_tx_nxt       = r_tx;
    w_done_nxt     = 1'b0;
    w_underrun_nxt = 1'b0;
    w_boundary     = 1'b0;
    w_ready        = 1'b0;
    w_emit         = 1'b0;
    w_emit_val     = 1'b0;
`ifdef USB_TX_BITSTUFF_EN
    w_ones_nxt     = r_ones;
`endif

    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (tx_valid) begin
          w_byte_nxt  = tx_data;
          w_last_nxt  = tx_last;
          w_bit_nxt   = '0;
          w_state_nxt = S_SYNC;
          w_tx_nxt    = 1'b1;
          w_emit      = 1'b1;
          w_emit_val  = 1'b0;
        end
      end
      S_SYNC: begin
        if (w_bit_end) begin
          w_emit = 1'b1;
          if (r_bit == 3'd7) begin
            w_state_nxt = S_DATA;
            w_bit_nxt   = '0;
            w_emit_val  = r_byte[0];
          end else begin
            w_bit_nxt  = r_bit + 3'd1;
            w_emit_val = (r_bit == 3'd6);
          end
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
`ifdef USB_TX_BITSTUFF_EN
          if (r_ones == 3'd6) begin
            w_state_nxt = S_STUFF;
            w_emit      = 1'b1;
            w_emit_val  = 1'b0;
          end else
`endif
          if (r_bit == 3'd7) begin
            w_boundary = 1'b1;
          end else begin
            w_bit_nxt  = r_bit + 3'd1;
            w_emit     = 1'b1;
            w_emit_val = r_byte[r_bit + 3'd1];
          end
        end
      end
`ifdef USB_TX_BITSTUFF_EN
      S_STUFF: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
          if (r_bit == 3'd7) begin
            w_boundary = 1'b1;
          end else begin
            w_bit_nxt  = r_bit + 3'd1;
            w_emit     = 1'b1;
            w_emit_val = r_byte[r_bit + 3'd1];
          end
        end
      end
`endif
      S_EOP_SE0: begin
        if (w_bit_end) begin
          if (r_bit == 3'd0) begin
            w_bit_nxt = 3'd1;
          end else begin
            w_bit_nxt   = '0;
            w_state_nxt = S_EOP_J;
          end
        end
      end
      S_EOP_J: begin
        if (w_bit_end) begin
          w_state_nxt    = S_IDLE;
          w_bit_nxt      = '0;
          w_tx_nxt       = 1'b0;
          w_done_nxt     = r_last;
          w_underrun_nxt = ~r_last;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Byte boundary: the last byte (or a missing next byte) leads into EOP;
    // otherwise the next byte is taken on this same cycle with no gap.
    if (w_boundary) begin
      w_bit_nxt = '0;
      if (r_last) begin
        w_state_nxt = S_EOP_SE0;
        w_nrzi_nxt  = 1'b1;
      end else begin
        w_ready = 1'b1;
        if (tx_valid) begin
          w_state_nxt = S_DATA;
          w_byte_nxt  = tx_data;
          w_last_nxt  = tx_last;
          w_emit      = 1'b1;
          w_emit_val  = tx_data[0];
        end else begin
          w_state_nxt = S_EOP_SE0;
          w_nrzi_nxt  = 1'b1;
        end
      end
    end

    if (w_emit) begin
      w_nrzi_nxt = w_emit_val ? r_nrzi : ~r_nrzi;
`ifdef USB_TX_BITSTUFF_EN
      w_ones_nxt = w_emit_val ? r_ones + 3'd1 : '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= S_IDLE;
      r_div      <= '0;
      r_bit      <= '0;
      r_byte     <= '0;
      r_last     <= 1'b0;
      r_nrzi     <= 1'b1;
      r_dp       <= 1'b1;
      r_dm       <= 1'b0;
      r_tx       <= 1'b0;
      r_done     <= 1'b0;
      r_underrun <= 1'b0;
`ifdef USB_TX_BITSTUFF_EN
      r_ones     <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_div      <= w_div_nxt;
      r_bit      <= w_bit_nxt;
      r_byte     <= w_byte_nxt;
      r_last     <= w_last_nxt;
      r_nrzi     <= w_nrzi_nxt;
      // Line is SE0 exactly while the next state is EOP_SE0.
      r_dp       <= (w_state_nxt != S_EOP_SE0) &  w_nrzi_nxt;
      r_dm       <= (w_state_nxt != S_EOP_SE0) & ~w_nrzi_nxt;
      r_tx       <= w_tx_nxt;
      r_done     <= w_done_nxt;
      r_underrun <= w_underrun_nxt;
`ifdef USB_TX_BITSTUFF_EN
      r_ones     <= w_ones_nxt;
`endif
    end
  end

  assign tx_ready     = w_ready;
  assign d_plus_out   = r_dp;
  assign d_minus_out  = r_dm;
  assign transmitting = r_tx;
  assign tx_done      = r_done;
  assign tx_underrun  = r_underrun;

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Self-checking bench for usb_tx_encoder: line symbols per bit time, packet
// duration, handshake and end-of-packet pulses against a bit-queue model.
module tb_usb_tx_encoder;
  localparam int CPB = 8;
`ifdef USB_TX_BITSTUFF_EN
  localparam bit STUFF_EN = 1'b1;
`else
  localparam bit STUFF_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_last = 1'b0;
  logic       tx_ready, d_plus_out, d_minus_out, transmitting, tx_done, tx_underrun;

  usb_tx_encoder #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .n_rst(n_rst), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_last(tx_last), .tx_ready(tx_ready), .d_plus_out(d_plus_out),
    .d_minus_out(d_minus_out), .transmitting(transmitting),
    .tx_done(tx_done), .tx_underrun(tx_underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] pkt[$];
  bit         pkt_last;
  logic [1:0] cap_sym[$];
  int cap_cycles, cap_done, cap_unr, cap_ready_cnt, cap_ready_first, cap_accepted, cap_latency;
  bit cap_timeout, cap_at_fall;
  logic [1:0] exp_sym[$];
  int exp_ready_first, exp_ready_cnt;

  // Drives one packet from pkt[] and records what the line did.
  task automatic run_packet();
    int idx = 0;
    int t = 0;
    int acc_cyc = -1;
    bit prev_tx = 1'b0;
    bit finished = 1'b0;
    cap_sym.delete();
    cap_cycles = 0; cap_done = 0; cap_unr = 0; cap_ready_cnt = 0;
    cap_ready_first = -1; cap_latency = -1; cap_at_fall = 1'b0;
    for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
      @(negedge clk);
      if (transmitting) begin
        if (t == 0 && acc_cyc >= 0) cap_latency = cyc - acc_cyc;
        if (t % CPB == CPB / 2) cap_sym.push_back({d_plus_out, d_minus_out});
        if (tx_ready) begin
          if (cap_ready_first < 0) cap_ready_first = t;
          cap_ready_cnt++;
        end
        t++;
      end
      if (tx_done) cap_done++;
      if (tx_underrun) cap_unr++;
      if (tx_done || tx_underrun) begin
        cap_at_fall = prev_tx && !transmitting;
        finished = 1'b1;
      end
      prev_tx = transmitting;
      if (!finished && idx < pkt.size()) begin
        tx_valid = 1'b1;
        tx_data  = pkt[idx];
        tx_last  = pkt_last && (idx == pkt.size() - 1);
      end else begin
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        tx_last  = 1'($urandom);
      end
      #1;
      if (tx_valid && tx_ready) begin
        if (idx == 0) acc_cyc = cyc;
        idx++;
      end
    end
    tx_valid = 1'b0;
    cap_cycles = t;
    cap_accepted = idx;
    cap_timeout = !finished;
  endtask

  // Reference: raw bit stream -> stuffing -> NRZI symbols -> EOP.
  function automatic void build_model();
    bit raw[$];
    bit stuffed[$];
    int ones = 0;
    int b0_end = 0;
    logic [1:0] lvl = 2'b10;
    for (int i = 0; i < 8; i++) raw.push_back(i == 7);
    for (int k = 0; k < pkt.size(); k++)
      for (int i = 0; i < 8; i++) raw.push_back(pkt[k][i]);
    for (int i = 0; i < raw.size(); i++) begin
      stuffed.push_back(raw[i]);
      ones = raw[i] ? ones + 1 : 0;
      if (STUFF_EN && ones == 6) begin
        stuffed.push_back(1'b0);
        ones = 0;
      end
      if (i == 15) b0_end = stuffed.size();
    end
    exp_sym.delete();
    foreach (stuffed[i]) begin
      if (!stuffed[i]) lvl = ~lvl;
      exp_sym.push_back(lvl);
    end
    exp_sym.push_back(2'b00);
    exp_sym.push_back(2'b00);
    exp_sym.push_back(2'b10);
    exp_ready_first = (pkt_last && pkt.size() == 1) ? -1 : b0_end * CPB - 1;
    exp_ready_cnt   = pkt_last ? pkt.size() - 1 : pkt.size();
  endfunction

  function automatic int first_diff();
    if (cap_sym.size() != exp_sym.size()) return 0;
    foreach (exp_sym[i]) if (cap_sym[i] !== exp_sym[i]) return i;
    return -1;
  endfunction

  task automatic test_reset();
    n_rst = 1'b0;
    #13;
    checks++; if (d_plus_out !== 1'b1) begin failures++; $display("FAIL reset_dp got=%b exp=1", d_plus_out); end
    checks++; if (d_minus_out !== 1'b0) begin failures++; $display("FAIL reset_dm got=%b exp=0", d_minus_out); end
    checks++; if (transmitting !== 1'b0) begin failures++; $display("FAIL reset_tx got=%b exp=0", transmitting); end
    checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", tx_ready); end
    checks++; if ({tx_done, tx_underrun} !== 2'b00) begin failures++; $display("FAIL reset_pulses got=%b exp=00", {tx_done, tx_underrun}); end
    @(negedge clk);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_zero();
    pkt = '{8'h00}; pkt_last = 1'b1;
    build_model();
    run_packet();
    checks++; if (cap_timeout) begin failures++; $display("FAIL zero_timeout got=timeout exp=finish"); end
    checks++; if (cap_latency !== 1) begin failures++; $display("FAIL zero_latency got=%0d exp=1", cap_latency); end
    checks++; if (cap_cycles !== 152) begin failures++; $display("FAIL zero_cycles got=%0d exp=152", cap_cycles); end
    checks++; if (first_diff() != -1) begin failures++; $display("FAIL zero_symbols at=%0d got_n=%0d exp_n=%0d", first_diff(), cap_sym.size(), exp_sym.size()); end
    checks++; if (cap_done !== 1 || cap_unr !== 0 || !cap_at_fall) begin failures++; $display("FAIL zero_pulses got done=%0d unr=%0d fall=%0d exp done=1 unr=0 fall=1", cap_done, cap_unr, cap_at_fall); end
  endtask

  task automatic test_single_ff();
    int exp_cyc;
    pkt = '{8'hFF}; pkt_last = 1'b1;
    exp_cyc = STUFF_EN ? 160 : 152;
    build_model();
    run_packet();
    checks++; if (cap_cycles !== exp_cyc) begin failures++; $display("FAIL ff_cycles got=%0d exp=%0d", cap_cycles, exp_cyc); end
    checks++; if (first_diff() != -1) begin failures++; $display("FAIL ff_symbols at=%0d got_n=%0d exp_n=%0d", first_diff(), cap_sym.size(), exp_sym.size()); end
    checks++; if (cap_done !== 1 || cap_unr !== 0) begin failures++; $display("FAIL ff_pulses got done=%0d unr=%0d exp done=1 unr=0", cap_done, cap_unr); end
  endtask

  task automatic test_back_to_back();
    pkt = '{8'hA5, 8'h3C}; pkt_last = 1'b1;
    build_model();
    run_packet();
    checks++; if (cap_cycles !== 216) begin failures++; $display("FAIL b2b_cycles got=%0d exp=216", cap_cycles); end
    checks++; if (cap_ready_cnt !== 1 || cap_ready_first !== 127) begin failures++; $display("FAIL b2b_ready got cnt=%0d pos=%0d exp cnt=1 pos=127", cap_ready_cnt, cap_ready_first); end
    checks++; if (first_diff() != -1) begin failures++; $display("FAIL b2b_symbols at=%0d got_n=%0d exp_n=%0d", first_diff(), cap_sym.size(), exp_sym.size()); end
    checks++; if (cap_done !== 1 || cap_accepted !== 2) begin failures++; $display("FAIL b2b_done got done=%0d acc=%0d exp done=1 acc=2", cap_done, cap_accepted); end
  endtask

  task automatic test_underrun();
    pkt = '{8'h01}; pkt_last = 1'b0;
    build_model();
    run_packet();
    checks++; if (cap_unr !== 1 || cap_done !== 0 || !cap_at_fall) begin failures++; $display("FAIL unr_pulses got unr=%0d done=%0d fall=%0d exp unr=1 done=0 fall=1", cap_unr, cap_done, cap_at_fall); end
    checks++; if (cap_cycles !== 152) begin failures++; $display("FAIL unr_cycles got=%0d exp=152", cap_cycles); end
    checks++; if (first_diff() != -1) begin failures++; $display("FAIL unr_symbols at=%0d got_n=%0d exp_n=%0d", first_diff(), cap_sym.size(), exp_sym.size()); end
    checks++; if (cap_ready_cnt !== 1) begin failures++; $display("FAIL unr_ready got=%0d exp=1", cap_ready_cnt); end
  endtask

  task automatic test_random();
    int n;
    for (int p = 0; p < 8; p++) begin
      n = $urandom_range(1, 4);
      pkt.delete();
      for (int k = 0; k < n; k++)
        pkt.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
      pkt_last = ($urandom_range(0, 3) != 0);
      build_model();
      run_packet();
      checks++; if (cap_cycles !== exp_sym.size() * CPB) begin failures++; $display("FAIL rnd%0d_cycles got=%0d exp=%0d", p, cap_cycles, exp_sym.size() * CPB); end
      checks++; if (first_diff() != -1) begin failures++; $display("FAIL rnd%0d_symbols at=%0d got_n=%0d exp_n=%0d", p, first_diff(), cap_sym.size(), exp_sym.size()); end
      checks++; if (cap_done !== int'(pkt_last) || cap_unr !== int'(!pkt_last)) begin failures++; $display("FAIL rnd%0d_pulses got done=%0d unr=%0d last=%0d", p, cap_done, cap_unr, pkt_last); end
      checks++; if (cap_ready_cnt !== exp_ready_cnt || cap_ready_first !== exp_ready_first) begin failures++; $display("FAIL rnd%0d_ready got cnt=%0d pos=%0d exp cnt=%0d pos=%0d", p, cap_ready_cnt, cap_ready_first, exp_ready_cnt, exp_ready_first); end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    tx_valid = 1'b1; tx_data = 8'h55; tx_last = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (CPB * 12) @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    checks++; if ({d_plus_out, d_minus_out} !== 2'b10 || transmitting !== 1'b0) begin failures++; $display("FAIL mid_reset_line got=%b%b tx=%b exp=10 tx=0", d_plus_out, d_minus_out, transmitting); end
    checks++; if (tx_ready !== 1'b1 || tx_done !== 1'b0 || tx_underrun !== 1'b0) begin failures++; $display("FAIL mid_reset_ctrl got ready=%b done=%b unr=%b exp 1 0 0", tx_ready, tx_done, tx_underrun); end
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    pkt = '{8'($urandom), 8'hFE}; pkt_last = 1'b1;
    build_model();
    run_packet();
    checks++; if (first_diff() != -1 || cap_done !== 1) begin failures++; $display("FAIL mid_reset_next at=%0d done=%0d exp_at=-1 done=1", first_diff(), cap_done); end
  endtask

  initial begin
    test_reset();
    test_single_zero();
    test_single_ff();
    test_back_to_back();
    test_underrun();
    test_random();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
